// File: rtl/clic_pkg.sv
// Shared CLIC definitions: acceptor FSM states, privilege mode encodings and
// the interrupt eligibility rule also used by the CSR-side mnxti logic.
package clic_pkg;

  localparam int N_SOURCE = 256;
  localparam int SRC_W    = $clog2(N_SOURCE);
  localparam int PRIO_W   = 8;
  localparam int MODE_W   = 2;

  typedef enum logic {
    IDLE,
    REQ
  } irq_acc_state_e;

  typedef enum logic [MODE_W-1:0] {
    MODE_U = 2'd0,
    MODE_S = 2'd1,
    MODE_M = 2'd3
  } priv_mode_e;

  // An interrupt targeting a more privileged mode is always taken. One that
  // targets the current mode needs the global enable and a level strictly
  // above both the running level and the threshold. Level 0 means "no
  // interrupt" and never qualifies.
  function automatic logic clic_irq_eligible(
    input logic [MODE_W-1:0] irq_mode,
    input logic [MODE_W-1:0] cur_mode,
    input logic              irq_en,
    input logic [PRIO_W-1:0] irq_level,
    input logic [PRIO_W-1:0] cur_level,
    input logic [PRIO_W-1:0] thresh
  );
    logic [PRIO_W-1:0] floor_level;
    floor_level = (cur_level > thresh) ? cur_level : thresh;
    return (irq_level != '0) &&
           ((irq_mode > cur_mode) ||
            ((irq_mode == cur_mode) && irq_en && (irq_level > floor_level)));
  endfunction

endpackage

// File: rtl/clic_irq_acceptor.sv
// Core-side receiver of the CLIC valid/ready + kill_req/kill_ack handshake.
// Captures an eligible offer, raises a registered trap request to the core,
// and completes, yields or withdraws the handshake as conditions change.
module clic_irq_acceptor
  import clic_pkg::*;
#(
  parameter  int N_SOURCE  = clic_pkg::N_SOURCE,
  parameter  int PrioWidth = PRIO_W,
  parameter  int ModeWidth = MODE_W,
  localparam int SrcWidth  = $clog2(N_SOURCE)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 irq_valid_i,
  output logic                 irq_ready_o,
  input  logic [SrcWidth-1:0]  irq_id_i,
  input  logic [PrioWidth-1:0] irq_level_i,
  input  logic [ModeWidth-1:0] irq_mode_i,
  input  logic                 irq_kill_req_i,
  output logic                 irq_kill_ack_o,
  input  logic [ModeWidth-1:0] cur_mode_i,
  input  logic                 irq_en_i,
  input  logic [PrioWidth-1:0] cur_level_i,
  input  logic [PrioWidth-1:0] thresh_i,
  output logic                 core_irq_req_o,
  output logic [SrcWidth-1:0]  core_irq_id_o,
  output logic [PrioWidth-1:0] core_irq_level_o,
  output logic [ModeWidth-1:0] core_irq_mode_o,
  input  logic                 core_irq_ack_i
);

  irq_acc_state_e       state_q;
  logic                 req_q;
  logic [SrcWidth-1:0]  id_q;
  logic [PrioWidth-1:0] level_q;
  logic [ModeWidth-1:0] mode_q;

  logic eligible;
  logic take;
  logic withdraw;

  // Handshake decode: the core commit outranks a kill arriving in the same
  // cycle, matching the CLIC which checks valid&ready before kill.
  always_comb begin
    eligible = clic_irq_eligible(irq_mode_i, cur_mode_i, irq_en_i,
                                 irq_level_i, cur_level_i, thresh_i);
    take     = (state_q == REQ) && core_irq_ack_i && irq_valid_i;
    withdraw = !irq_valid_i || (irq_id_i != id_q) || !eligible;
    // Pulses are suppressed while reset is asserted so the CLIC never sees a
    // completion or abort for a handshake that reset is discarding.
    irq_ready_o    = !rst_i && take;
    irq_kill_ack_o = !rst_i && irq_kill_req_i && !take;
  end

  // Acceptor FSM with registered request and captured interrupt attributes.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      id_q    <= '0;
      level_q <= '0;
      mode_q  <= MODE_U;
    end else begin
      case (state_q)
        IDLE: begin
          if (irq_valid_i && eligible && !irq_kill_req_i) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            id_q    <= irq_id_i;
            level_q <= irq_level_i;
            mode_q  <= irq_mode_i;
          end
        end
        REQ: begin
          // Commit, kill and withdraw all return to IDLE; captured values
          // are held so the core can still read what it just took.
          if (take || irq_kill_req_i || withdraw) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          req_q   <= 1'b0;
        end
      endcase
    end
  end

  assign core_irq_req_o   = req_q;
  assign core_irq_id_o    = id_q;
  assign core_irq_level_o = level_q;
  assign core_irq_mode_o  = mode_q;

endmodule

// File: tb/tb_clic_irq_acceptor.sv
// Directed, table-driven bench for clic_irq_acceptor. Each vector is one
// clock cycle: inputs are driven after the falling edge, outputs are checked
// 1ns later (registered outputs show the state entering that cycle, ready and
// kill_ack show the combinational response), then the rising edge commits.
module tb_clic_irq_acceptor;
  import clic_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       ready;
  logic [7:0] id;
  logic [7:0] lvl;
  logic [1:0] mode;
  logic       kill;
  logic       kill_ack;
  logic [1:0] cur_mode;
  logic       en;
  logic [7:0] cur_lvl;
  logic [7:0] thresh;
  logic       req;
  logic [7:0] req_id;
  logic [7:0] req_lvl;
  logic [1:0] req_mode;
  logic       ack;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  clic_irq_acceptor dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .irq_valid_i      (valid),
    .irq_ready_o      (ready),
    .irq_id_i         (id),
    .irq_level_i      (lvl),
    .irq_mode_i       (mode),
    .irq_kill_req_i   (kill),
    .irq_kill_ack_o   (kill_ack),
    .cur_mode_i       (cur_mode),
    .irq_en_i         (en),
    .cur_level_i      (cur_lvl),
    .thresh_i         (thresh),
    .core_irq_req_o   (req),
    .core_irq_id_o    (req_id),
    .core_irq_level_o (req_lvl),
    .core_irq_mode_o  (req_mode),
    .core_irq_ack_i   (ack)
  );

  typedef struct {
    logic       rst;
    logic       valid;
    logic [7:0] id;
    logic [7:0] lvl;
    logic [1:0] mode;
    logic       kill;
    logic       ack;
    logic [1:0] cur_mode;
    logic       en;
    logic [7:0] cur_lvl;
    logic [7:0] thresh;
    logic       e_req;
    logic [7:0] e_id;
    logic       e_ready;
    logic       e_kack;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(
    input logic rst_v, input logic valid_v, input logic [7:0] id_v, input logic [7:0] lvl_v,
    input logic [1:0] mode_v, input logic kill_v, input logic ack_v,
    input logic [1:0] cm_v, input logic en_v, input logic [7:0] cl_v, input logic [7:0] th_v,
    input logic e_req_v, input logic [7:0] e_id_v, input logic e_ready_v, input logic e_kack_v);
    vec_t v;
    v.rst = rst_v; v.valid = valid_v; v.id = id_v; v.lvl = lvl_v; v.mode = mode_v;
    v.kill = kill_v; v.ack = ack_v; v.cur_mode = cm_v; v.en = en_v; v.cur_lvl = cl_v;
    v.thresh = th_v; v.e_req = e_req_v; v.e_id = e_id_v; v.e_ready = e_ready_v;
    v.e_kack = e_kack_v;
    return v;
  endfunction

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    rst = v.rst; valid = v.valid; id = v.id; lvl = v.lvl; mode = v.mode;
    kill = v.kill; ack = v.ack; cur_mode = v.cur_mode; en = v.en;
    cur_lvl = v.cur_lvl; thresh = v.thresh;
    #1;
    check($sformatf("v%0d req", idx),      {31'd0, req},      {31'd0, v.e_req});
    check($sformatf("v%0d id", idx),       {24'd0, req_id},   {24'd0, v.e_id});
    check($sformatf("v%0d ready", idx),    {31'd0, ready},    {31'd0, v.e_ready});
    check($sformatf("v%0d kill_ack", idx), {31'd0, kill_ack}, {31'd0, v.e_kack});
  endtask

  localparam logic [1:0] U = MODE_U;
  localparam logic [1:0] S = MODE_S;
  localparam logic [1:0] M = MODE_M;

  initial begin
    rst = 1'b1; valid = 0; id = 0; lvl = 0; mode = 0; kill = 0; ack = 0;
    cur_mode = 0; en = 0; cur_lvl = 0; thresh = 0;
    repeat (2) @(posedge clk);

    //          rst vld id     lvl    mode kill ack cm en cl     th      req id    rdy kack
    // reset state
    vecs.push_back(mk(0, 0, 8'd0, 8'h00, U, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd0, 0, 0));
    // 1: higher mode offer, captured, then committed
    vecs.push_back(mk(0, 1, 8'd5, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd0, 0, 0));
    vecs.push_back(mk(0, 1, 8'd5, 8'h40, M, 0, 1, U, 0, 8'h00, 8'h00,  1, 8'd5, 1, 0));
    vecs.push_back(mk(0, 0, 8'd5, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd5, 0, 0));
    // 2: same mode, level below threshold, then threshold lowered
    vecs.push_back(mk(0, 1, 8'd7, 8'h40, M, 0, 0, M, 1, 8'h30, 8'h50,  0, 8'd5, 0, 0));
    vecs.push_back(mk(0, 1, 8'd7, 8'h40, M, 0, 0, M, 1, 8'h30, 8'h20,  0, 8'd5, 0, 0));
    vecs.push_back(mk(0, 1, 8'd7, 8'h40, M, 0, 0, M, 1, 8'h30, 8'h20,  1, 8'd7, 0, 0));
    // 5: valid drops while requesting -> withdraw, no ready
    vecs.push_back(mk(0, 0, 8'd7, 8'h40, M, 0, 0, M, 1, 8'h30, 8'h20,  1, 8'd7, 0, 0));
    vecs.push_back(mk(0, 0, 8'd7, 8'h40, M, 0, 0, M, 1, 8'h30, 8'h20,  0, 8'd7, 0, 0));
    // 3: kill in REQ, then a new offer id 9
    vecs.push_back(mk(0, 1, 8'd5, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd7, 0, 0));
    vecs.push_back(mk(0, 1, 8'd5, 8'h40, M, 1, 0, U, 0, 8'h00, 8'h00,  1, 8'd5, 0, 1));
    vecs.push_back(mk(0, 1, 8'd9, 8'hC0, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd5, 0, 0));
    vecs.push_back(mk(0, 1, 8'd9, 8'hC0, M, 0, 0, U, 0, 8'h00, 8'h00,  1, 8'd9, 0, 0));
    vecs.push_back(mk(0, 1, 8'd9, 8'hC0, M, 0, 1, U, 0, 8'h00, 8'h00,  1, 8'd9, 1, 0));
    vecs.push_back(mk(0, 0, 8'd9, 8'hC0, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd9, 0, 0));
    // 4: kill and core ack together -> handshake wins
    vecs.push_back(mk(0, 1, 8'd5, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd9, 0, 0));
    vecs.push_back(mk(0, 1, 8'd5, 8'h40, M, 1, 1, U, 0, 8'h00, 8'h00,  1, 8'd5, 1, 0));
    vecs.push_back(mk(0, 0, 8'd5, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd5, 0, 0));
    // kill in IDLE: acked, and blocks capture of an eligible offer
    vecs.push_back(mk(0, 0, 8'd5, 8'h40, M, 1, 0, U, 0, 8'h00, 8'h00,  0, 8'd5, 0, 1));
    vecs.push_back(mk(0, 1, 8'd6, 8'h40, M, 1, 0, U, 0, 8'h00, 8'h00,  0, 8'd5, 0, 1));
    vecs.push_back(mk(0, 0, 8'd6, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd5, 0, 0));
    // core ack in IDLE ignored (offer still captured)
    vecs.push_back(mk(0, 1, 8'd3, 8'h40, M, 0, 1, U, 0, 8'h00, 8'h00,  0, 8'd5, 0, 0));
    vecs.push_back(mk(0, 1, 8'd3, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  1, 8'd3, 0, 0));
    // id changes under REQ -> withdraw, re-capture next cycle
    vecs.push_back(mk(0, 1, 8'd4, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  1, 8'd3, 0, 0));
    vecs.push_back(mk(0, 1, 8'd4, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd3, 0, 0));
    // core ack with valid low -> no ready, withdraw
    vecs.push_back(mk(0, 0, 8'd4, 8'h40, M, 0, 1, U, 0, 8'h00, 8'h00,  1, 8'd4, 0, 0));
    vecs.push_back(mk(0, 0, 8'd4, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd4, 0, 0));
    // level 0 never eligible, even to a higher mode
    vecs.push_back(mk(0, 1, 8'd2, 8'h00, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd4, 0, 0));
    // same mode, level equal to max(cur_level, thresh) -> not eligible
    vecs.push_back(mk(0, 1, 8'd2, 8'h30, M, 0, 0, M, 1, 8'h30, 8'h30,  0, 8'd4, 0, 0));
    // same mode, level high enough but global enable off
    vecs.push_back(mk(0, 1, 8'd2, 8'h40, M, 0, 0, M, 0, 8'h00, 8'h00,  0, 8'd4, 0, 0));
    // lower target mode than current
    vecs.push_back(mk(0, 1, 8'd2, 8'hFF, S, 0, 0, M, 1, 8'h00, 8'h00,  0, 8'd4, 0, 0));
    // same mode, one above cur_level which exceeds thresh -> eligible
    vecs.push_back(mk(0, 1, 8'd2, 8'h31, S, 0, 0, S, 1, 8'h30, 8'h10,  0, 8'd4, 0, 0));
    vecs.push_back(mk(0, 1, 8'd2, 8'h31, S, 0, 1, S, 1, 8'h30, 8'h10,  1, 8'd2, 1, 0));
    vecs.push_back(mk(0, 0, 8'd2, 8'h31, S, 0, 0, S, 1, 8'h30, 8'h10,  0, 8'd2, 0, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // 6: reset while requesting; ack and kill during reset must not pulse
    vecs.delete();
    vecs.push_back(mk(0, 1, 8'd6, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd2, 0, 0));
    vecs.push_back(mk(1, 1, 8'd6, 8'h40, M, 1, 1, U, 0, 8'h00, 8'h00,  1, 8'd6, 0, 0));
    vecs.push_back(mk(0, 1, 8'd6, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd0, 0, 0));
    vecs.push_back(mk(0, 1, 8'd6, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  1, 8'd6, 0, 0));
    vecs.push_back(mk(0, 1, 8'd6, 8'h40, M, 0, 1, U, 0, 8'h00, 8'h00,  1, 8'd6, 1, 0));
    vecs.push_back(mk(0, 0, 8'd6, 8'h40, M, 0, 0, U, 0, 8'h00, 8'h00,  0, 8'd6, 0, 0));
    foreach (vecs[i]) apply(vecs[i], 100 + i);

    // captured level and mode follow the last capture (id 6, 8'h40, M)
    check("cap level", {24'd0, req_lvl}, 32'h40);
    check("cap mode",  {30'd0, req_mode}, {30'd0, M});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
